dmem_arbiter: RTL

Two-port arbiter that shares the single-port 16-bit data memory between the CPU data port (requester 0) and an auxiliary master such as a loader or DMA engine (requester 1). It accepts one request per cycle, issues a registered memory operation, and returns read data to the owning requester. Read data is returned through a fixed-latency pipeline. The block sits between the CPU's DA/DD/RW data interface and the data memory array.

---
 rtl/dmem_arbiter_if.sv | 36 +++
 rtl/dmem_arbiter.sv | 122 ++++++++++++
 2 files changed

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two data-memory requesters, the arbiter and the memory array.
// The slave modport is the arbiter's view. The master modport is the requesters plus the memory.
interface dmem_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 16
) ();
    logic          req0;
    logic          req1;
    logic          rw0;
    logic          rw1;
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
    logic [DW-1:0] wd0;
    logic [DW-1:0] wd1;
    logic          gnt0;
    logic          gnt1;
    logic          rdv0;
    logic          rdv1;
    logic [DW-1:0] rd;
    logic          men;
    logic          mrw;
    logic [AW-1:0] ma;
    logic [DW-1:0] mwd;
    logic [DW-1:0] mrd;
    logic          busy;

    modport slave (
        input  req0, req1, rw0, rw1, a0, a1, wd0, wd1, mrd,
        output gnt0, gnt1, rdv0, rdv1, rd, men, mrw, ma, mwd, busy
    );

    modport master (
        output req0, req1, rw0, rw1, a0, a1, wd0, wd1, mrd,
        input  gnt0, gnt1, rdv0, rdv1, rd, men, mrw, ma, mwd, busy
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter that shares a single-port data memory between the CPU (0) and an aux master (1).
// Read data comes back through a fixed two-stage pipeline, so RD/RDV appear three cycles after the request.
module dmem_arbiter #(
    parameter int AW = 16,
    parameter int DW = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    dmem_arbiter_if.slave     bus_if
);
    logic          gnt0_q, gnt0_d;
    logic          gnt1_q, gnt1_d;
    logic          men_q, men_d;
    logic          mrw_q, mrw_d;
    logic [AW-1:0] ma_q, ma_d;
    logic [DW-1:0] mwd_q, mwd_d;
    logic          own1_q, own1_d;
    logic          s2_rd_q, s2_rd_d;
    logic          s2_own_q, s2_own_d;
    logic [DW-1:0] rd_q, rd_d;
    logic          rdv0_q, rdv0_d;
    logic          rdv1_q, rdv1_d;
    logic          busy_q, busy_d;
    logic          last_q, last_d;
    logic          elig0_s, elig1_s, sel1_s, grant_s;

    // Arbitration, stage-1 issue, stage-2 advance and read-data return
    always_comb begin
        // a requester whose GNT is visible this cycle is still holding its stale REQ
        elig0_s  = bus_if.req0 & ~gnt0_q;
        elig1_s  = bus_if.req1 & ~gnt1_q;
        sel1_s   = elig1_s & (~elig0_s | ~last_q);
        grant_s  = elig0_s | elig1_s;

        gnt0_d   = 1'b0;
        gnt1_d   = 1'b0;
        men_d    = 1'b0;
        mrw_d    = mrw_q;
        ma_d     = ma_q;
        mwd_d    = mwd_q;
        own1_d   = own1_q;
        last_d   = last_q;

        if (grant_s) begin
            men_d  = 1'b1;
            own1_d = sel1_s;
            last_d = sel1_s;
            if (sel1_s) begin
                gnt1_d = 1'b1;
                mrw_d  = bus_if.rw1;
                ma_d   = bus_if.a1;
                mwd_d  = bus_if.wd1;
            end else begin
                gnt0_d = 1'b1;
                mrw_d  = bus_if.rw0;
                ma_d   = bus_if.a0;
                mwd_d  = bus_if.wd0;
            end
        end else begin
            men_d  = 1'b0;
        end

        s2_rd_d  = men_q & mrw_q;
        s2_own_d = own1_q;

        rdv0_d   = s2_rd_q & ~s2_own_q;
        rdv1_d   = s2_rd_q & s2_own_q;
        if (s2_rd_q) begin
            rd_d = bus_if.mrd;
        end else begin
            rd_d = rd_q;
        end

        busy_d   = (men_d & mrw_d) | s2_rd_d;
    end

    // State registers; reset discards any in-flight read
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            men_q    <= 1'b0;
            mrw_q    <= 1'b1;
            ma_q     <= {AW{1'b0}};
            mwd_q    <= {DW{1'b0}};
            own1_q   <= 1'b0;
            s2_rd_q  <= 1'b0;
            s2_own_q <= 1'b0;
            rd_q     <= {DW{1'b0}};
            rdv0_q   <= 1'b0;
            rdv1_q   <= 1'b0;
            busy_q   <= 1'b0;
            last_q   <= 1'b1;
        end else begin
            gnt0_q   <= gnt0_d;
            gnt1_q   <= gnt1_d;
            men_q    <= men_d;
            mrw_q    <= mrw_d;
            ma_q     <= ma_d;
            mwd_q    <= mwd_d;
            own1_q   <= own1_d;
            s2_rd_q  <= s2_rd_d;
            s2_own_q <= s2_own_d;
            rd_q     <= rd_d;
            rdv0_q   <= rdv0_d;
            rdv1_q   <= rdv1_d;
            busy_q   <= busy_d;
            last_q   <= last_d;
        end
    end

    assign bus_if.gnt0 = gnt0_q;
    assign bus_if.gnt1 = gnt1_q;
    assign bus_if.men  = men_q;
    assign bus_if.mrw  = mrw_q;
    assign bus_if.ma   = ma_q;
    assign bus_if.mwd  = mwd_q;
    assign bus_if.rd   = rd_q;
    assign bus_if.rdv0 = rdv0_q;
    assign bus_if.rdv1 = rdv1_q;
    assign bus_if.busy = busy_q;
endmodule
